// File: rtl/scmp_bus_pak.sv
// Shared types and constants for the SC/MP bus responder.
package scmp_bus_pak;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    DONE    = 2'd3
  } RESP_STATE_t;

  typedef struct packed {
    logic h;
    logic d;
    logic i;
    logic r;
  } BUS_FLAGS_t;

  localparam logic [7:0] TO_DATA_DEF = 8'hFF;

endpackage

// File: rtl/scmp_bus_responder_if.sv
// CPU-side SC/MP bus: strobes and flags from the sequencer, read data and stall back.
interface scmp_bus_responder_if #(
  parameter int ADDR_W = 16
) ();

  logic              ADS_n;
  logic              RD_n;
  logic              WR_n;
  logic              F_R;
  logic              F_I;
  logic              F_D;
  logic              F_H;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        dout;
  logic [7:0]        din;
  logic              hold;

  modport master (
    output ADS_n, RD_n, WR_n, F_R, F_I, F_D, F_H, addr, dout,
    input  din, hold
  );

  modport slave (
    input  ADS_n, RD_n, WR_n, F_R, F_I, F_D, F_H, addr, dout,
    output din, hold
  );

endinterface

// File: rtl/scmp_bus_wait_timer.sv
// Wait-cycle counter for a pending memory request; tc marks the last allowed wait cycle.
module scmp_bus_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  if (TIMEOUT == 0) begin : g_off
    assign tc = 1'b0;
  end else begin : g_on
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;

    // tc fires on the TIMEOUT-th waiting cycle, so the request is dropped after exactly TIMEOUT cycles
    assign tc = en && (cnt == CW'(TIMEOUT - 1));

    // count waiting cycles; held at zero while no request is outstanding
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
      end else if (clr) begin
        cnt <= '0;
      end else if (en && !tc) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/scmp_bus_responder.sv
// Memory-side responder: turns SC/MP bus strobes into single req/ack memory transactions
// and stalls the sequencer with bus_hold until the access completes.
module scmp_bus_responder
  import scmp_bus_pak::*;
#(
  parameter int         ADDR_W  = 16,
  parameter int         TIMEOUT = 255,
  parameter logic [7:0] TO_DATA = TO_DATA_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  scmp_bus_responder_if.slave bus,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic [3:0]        cyc_flags,
  output logic              halt_pulse,
  output logic              err_timeout,
  output logic              err_proto
);

  RESP_STATE_t state;
  BUS_FLAGS_t  flags_q;
  logic [7:0]  din_q;
  logic        ads;
  logic        rd;
  logic        wr;
  logic        waiting;
  logic        to_tc;

  assign ads     = ~bus.ADS_n;
  assign rd      = ~bus.RD_n;
  assign wr      = ~bus.WR_n;
  assign waiting = (state == RD_WAIT) || (state == WR_WAIT);

  scmp_bus_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (~waiting),
    .en    (waiting),
    .tc    (to_tc)
  );

  // Stall is combinational so the very first strobe cycle already freezes the PC;
  // gated by reset so the sequencer is never left stalled while we are held in reset.
  assign bus.hold  = rst_n & (rd | wr) & (state != DONE);
  assign bus.din   = din_q;
  assign cyc_flags = flags_q;

  // bus cycle FSM with address/flag latch, access launch, completion and error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= 8'h00;
      din_q       <= 8'h00;
      flags_q     <= '0;
      halt_pulse  <= 1'b0;
      err_timeout <= 1'b0;
      err_proto   <= 1'b0;
    end else begin
      halt_pulse <= 1'b0;
      case (state)
        IDLE, DONE: begin
          // ADS and a strobe in the same cycle: mem_addr picks up the incoming address
          if (ads) begin
            mem_addr   <= bus.addr;
            flags_q    <= '{h: bus.F_H, d: bus.F_D, i: bus.F_I, r: bus.F_R};
            halt_pulse <= bus.F_H;
          end
          if (state == DONE) begin
            // strobes must both be seen high before another access is accepted
            if (!rd && !wr) state <= IDLE;
          end else if (rd && wr) begin
            err_proto <= 1'b1;
          end else if (rd) begin
            state   <= RD_WAIT;
            mem_req <= 1'b1;
            mem_we  <= 1'b0;
          end else if (wr) begin
            state     <= WR_WAIT;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_wdata <= bus.dout;
          end
        end
        RD_WAIT, WR_WAIT: begin
          if (ads) err_proto <= 1'b1;
          // an ack coinciding with the timeout is a normal completion
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= DONE;
            if (state == RD_WAIT) din_q <= mem_rdata;
          end else if (to_tc) begin
            mem_req     <= 1'b0;
            err_timeout <= 1'b1;
            state       <= DONE;
            if (state == RD_WAIT) din_q <= TO_DATA;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scmp_bus_responder.sv
// Directed bench: two responders (default timeout and TIMEOUT=4) behind a shared CPU stimulus,
// with a scoreboard of expected memory transactions checked at each mem_req rise.
module tb_scmp_bus_responder;
  import scmp_bus_pak::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        ads_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
  logic [3:0]  flags = 4'h0;
  logic [15:0] addr = 16'h0;
  logic [7:0]  dout = 8'h0;
  logic        sel = 1'b0;
  logic [7:0]  rdata = 8'h0;
  logic        ack = 1'b0;
  logic        ack_force = 1'b0;

  scmp_bus_responder_if #(.ADDR_W(16)) bif ();
  scmp_bus_responder_if #(.ADDR_W(16)) bif_t ();

  assign bif.ADS_n   = ads_n | sel;
  assign bif.RD_n    = rd_n | sel;
  assign bif.WR_n    = wr_n | sel;
  assign bif_t.ADS_n = ads_n | ~sel;
  assign bif_t.RD_n  = rd_n | ~sel;
  assign bif_t.WR_n  = wr_n | ~sel;
  assign bif.F_H = flags[3];   assign bif.F_D = flags[2];
  assign bif.F_I = flags[1];   assign bif.F_R = flags[0];
  assign bif_t.F_H = flags[3]; assign bif_t.F_D = flags[2];
  assign bif_t.F_I = flags[1]; assign bif_t.F_R = flags[0];
  assign bif.addr = addr;   assign bif.dout = dout;
  assign bif_t.addr = addr; assign bif_t.dout = dout;

  logic req_a, we_a, halt_a, eto_a, epr_a;
  logic [15:0] maddr_a;
  logic [7:0]  wd_a;
  logic [3:0]  cf_a;
  logic req_t, we_t, halt_t, eto_t, epr_t;
  logic [15:0] maddr_t;
  logic [7:0]  wd_t;
  logic [3:0]  cf_t;

  scmp_bus_responder #(.ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif),
    .mem_req(req_a), .mem_we(we_a), .mem_addr(maddr_a), .mem_wdata(wd_a),
    .mem_rdata(rdata), .mem_ack(ack & ~sel),
    .cyc_flags(cf_a), .halt_pulse(halt_a), .err_timeout(eto_a), .err_proto(epr_a)
  );

  scmp_bus_responder #(.ADDR_W(16), .TIMEOUT(4)) dut_t (
    .clk(clk), .rst_n(rst_n), .bus(bif_t),
    .mem_req(req_t), .mem_we(we_t), .mem_addr(maddr_t), .mem_wdata(wd_t),
    .mem_rdata(rdata), .mem_ack(ack & sel),
    .cyc_flags(cf_t), .halt_pulse(halt_t), .err_timeout(eto_t), .err_proto(epr_t)
  );

  logic req_s, we_s, hold_s, halt_s, eto_s, epr_s;
  logic [15:0] maddr_s;
  logic [7:0]  wd_s, din_s;
  logic [3:0]  cf_s;
  assign req_s   = sel ? req_t : req_a;
  assign we_s    = sel ? we_t : we_a;
  assign hold_s  = sel ? bif_t.hold : bif.hold;
  assign halt_s  = sel ? halt_t : halt_a;
  assign eto_s   = sel ? eto_t : eto_a;
  assign epr_s   = sel ? epr_t : epr_a;
  assign maddr_s = sel ? maddr_t : maddr_a;
  assign wd_s    = sel ? wd_t : wd_a;
  assign din_s   = sel ? bif_t.din : bif.din;
  assign cf_s    = sel ? cf_t : cf_a;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic        we;
    logic [15:0] a;
    logic [7:0]  wd;
  } txn_t;
  txn_t exp_q[$];
  txn_t e;

  int   ack_delay = -1;
  int   req_len = 0;
  int   last_req_len = 0;
  int   req_rises = 0;
  logic req_prev = 1'b0;

  // memory model: scoreboard check on each new request, ack after ack_delay request cycles
  always @(negedge clk) begin
    if (req_s && !req_prev) begin
      req_rises++;
      chk("sb_pending", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("req_we", we_s, e.we);
        chk("req_addr", maddr_s, e.a);
        if (e.we) chk("req_wdata", wd_s, e.wd);
      end
    end
    if (req_s) begin
      ack = (ack_delay >= 0) && (req_len == ack_delay);
      req_len++;
    end else begin
      if (req_prev) last_req_len = req_len;
      req_len = 0;
      ack = ack_force;
    end
    req_prev = req_s;
  end

  task automatic ads_cycle(input logic [15:0] a, input logic [3:0] fl);
    @(negedge clk);
    ads_n = 1'b0; addr = a; flags = fl;
    @(negedge clk);
    ads_n = 1'b1;
  endtask

  task automatic access(input bit is_wr, input bit with_ads, input logic [15:0] a,
                        input logic [3:0] fl, input logic [7:0] wd, input logic [7:0] rd,
                        input int dly, input int linger, output int hold_n);
    txn_t t;
    t.we = is_wr; t.a = a; t.wd = wd;
    exp_q.push_back(t);
    ack_delay = dly;
    rdata = rd;
    @(negedge clk);
    if (with_ads) begin
      ads_n = 1'b0; addr = a; flags = fl;
    end
    dout = wd;
    if (is_wr) wr_n = 1'b0; else rd_n = 1'b0;
    hold_n = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!hold_s) break;
      hold_n++;
      @(negedge clk);
      ads_n = 1'b1;
    end
    repeat (linger) @(negedge clk);
    if (linger > 0) begin
      #1 chk("linger_hold", hold_s, 0);
    end
    rd_n = 1'b1; wr_n = 1'b1; ads_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before the end of the sequence");
    $fatal(1, "watchdog");
  end

  initial begin
    int h;
    int r0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", req_s, 0);
    chk("rst_we", we_s, 0);
    chk("rst_addr", maddr_s, 0);
    chk("rst_din", din_s, 0);
    chk("rst_hold", hold_s, 0);
    chk("rst_flags", cf_s, 0);
    chk("rst_halt", halt_s, 0);
    chk("rst_eto", eto_s, 0);
    chk("rst_epr", epr_s, 0);
    rst_n = 1'b1;

    ads_cycle(16'h1234, 4'b0010);
    chk("ads_addr", maddr_s, 16'h1234);
    chk("ads_flags", cf_s, 4'b0010);
    chk("ads_no_halt", halt_s, 0);
    access(1'b0, 1'b0, 16'h1234, 4'h0, 8'h00, 8'hA5, 0, 0, h);
    chk("rd_hold_cycles", h, 2);
    chk("rd_din", din_s, 8'hA5);
    chk("rd_req_len", last_req_len, 1);

    access(1'b1, 1'b1, 16'h0F00, 4'h0, 8'h3C, 8'h00, 5, 0, h);
    chk("wr_hold_cycles", h, 7);
    chk("wr_req_len", last_req_len, 6);
    chk("wr_din_kept", din_s, 8'hA5);
    chk("wr_flags", cf_s, 4'b0000);

    r0 = req_rises;
    access(1'b0, 1'b0, 16'h0F00, 4'h0, 8'h00, 8'h4E, 0, 10, h);
    chk("linger_hold_cycles", h, 2);
    chk("linger_one_req", req_rises - r0, 1);
    chk("linger_din", din_s, 8'h4E);
    access(1'b0, 1'b0, 16'h0F00, 4'h0, 8'h00, 8'h61, 1, 0, h);
    chk("next_hold_cycles", h, 3);
    chk("next_din", din_s, 8'h61);

    @(posedge clk);
    #1 rdata = 8'h77; ack_force = 1'b1;
    repeat (2) @(negedge clk);
    #1 ack_force = 1'b0;
    @(negedge clk);
    #1;
    chk("stray_ack_din", din_s, 8'h61);
    chk("stray_ack_req", req_s, 0);

    ads_cycle(16'h2000, 4'b1000);
    chk("halt_on", halt_s, 1);
    chk("halt_flags", cf_s, 4'b1000);
    @(negedge clk);
    #1 chk("halt_off", halt_s, 0);

    chk("proto_before", epr_s, 0);
    r0 = req_rises;
    @(negedge clk);
    rd_n = 1'b0; wr_n = 1'b0;
    @(negedge clk);
    rd_n = 1'b1; wr_n = 1'b1;
    @(negedge clk);
    #1;
    chk("proto_set", epr_s, 1);
    chk("proto_no_req", req_rises - r0, 0);
    chk("proto_req_low", req_s, 0);
    chk("main_no_timeout", eto_a, 0);

    sel = 1'b1;
    access(1'b0, 1'b1, 16'h0042, 4'h0, 8'h00, 8'hC3, 3, 0, h);
    chk("tie_hold_cycles", h, 5);
    chk("tie_din", din_s, 8'hC3);
    chk("tie_no_eto", eto_s, 0);
    access(1'b0, 1'b1, 16'h0043, 4'h0, 8'h00, 8'h11, -1, 0, h);
    chk("to_hold_cycles", h, 5);
    chk("to_req_len", last_req_len, 4);
    chk("to_din", din_s, 8'hFF);
    chk("to_eto", eto_s, 1);
    access(1'b1, 1'b0, 16'h0043, 4'h0, 8'h99, 8'h00, 1, 0, h);
    chk("after_to_hold", h, 3);
    chk("after_to_eto_sticky", eto_s, 1);
    sel = 1'b0;

    exp_q.push_back('{we: 1'b0, a: 16'h5555, wd: 8'h00});
    ack_delay = -1;
    @(negedge clk);
    ads_n = 1'b0; addr = 16'h5555; rd_n = 1'b0;
    @(negedge clk);
    ads_n = 1'b1;
    @(negedge clk);
    chk("mid_req_high", req_s, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_req", req_s, 0);
    chk("mid_rst_hold", hold_s, 0);
    chk("mid_rst_addr", maddr_s, 0);
    chk("mid_rst_epr", epr_s, 0);
    rd_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    access(1'b0, 1'b1, 16'h0000, 4'h0, 8'h00, 8'h08, 0, 0, h);
    chk("post_rst_hold", h, 2);
    chk("post_rst_din", din_s, 8'h08);
    chk("post_rst_addr", maddr_s, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
